gor16: RTL and testbench

GOR16 -- requirements
Module: gor16

---
 rtl/gor16_pkg.sv | 11 +
 rtl/gor16_popcnt.sv | 21 ++
 rtl/gor16.sv | 62 ++++++
 tb/tb_gor16.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/gor16_pkg.sv
// Shared constants for the GOR16 bitwise-OR block.
package gor16_pkg;

  // Default operand and result width in bits.
  localparam int unsigned DEFAULT_WIDTH = 16;

  // Width of the set-bit count. It holds 0..DEFAULT_WIDTH inclusive, so it needs one bit more
  // than log2.
  localparam int unsigned CNT_W = $clog2(DEFAULT_WIDTH) + 1;

endpackage

// File: rtl/gor16_popcnt.sv
// Purely combinational population count of a WIDTH-bit vector.
module gor16_popcnt
  import gor16_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]       bits,
  output logic [$clog2(WIDTH):0] count
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  // Ripple-add every bit; the result is wide enough for the all-ones case.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count = count + CntW'(bits[i]);
    end
  end

endmodule

// File: rtl/gor16.sv
// GOR16: combinational bitwise OR with reduction flags, a set-bit count,
// a registered result with a valid strobe, and a sticky OR accumulator.
module gor16
  import gor16_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   in_valid,
  input  logic                   acc_clr,
  output logic [WIDTH-1:0]       y,
  output logic                   any,
  output logic                   all,
  output logic [$clog2(WIDTH):0] cnt,
  output logic [WIDTH-1:0]       y_q,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       acc
);

  logic [WIDTH-1:0] acc_base;

  // Zero-latency OR and its reductions; reset does not touch this path.
  always_comb begin
    y   = a | b;
    any = |y;
    all = &y;
  end

  gor16_popcnt #(
    .WIDTH (WIDTH)
  ) u_popcnt (
    .bits  (y),
    .count (cnt)
  );

  // A clear in the same cycle as a valid operand drops the old contents before the
  // operand is ORed in.
  always_comb begin
    acc_base = acc_clr ? '0 : acc;
  end

  // Registered result, valid strobe and accumulator; there is no backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= '0;
      out_valid <= 1'b0;
      acc       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q <= a | b;
        acc <= acc_base | a | b;
      end else if (acc_clr) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gor16.sv
// Self-checking bench for gor16: a combinational vector table plus
// directed sequences for the registered path, accumulator and reset.
module tb_gor16;

  localparam int unsigned W = 16;

  logic          clk;
  logic          rst;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          in_valid;
  logic          acc_clr;
  logic [W-1:0]  y;
  logic          any;
  logic          all;
  logic [4:0]    cnt;
  logic [W-1:0]  y_q;
  logic          out_valid;
  logic [W-1:0]  acc;

  int nchk;
  int nfail;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_y;
    logic         exp_any;
    logic         exp_all;
    logic [4:0]   exp_cnt;
  } vec_t;

  vec_t vecs [10];

  gor16 #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .acc_clr   (acc_clr),
    .y         (y),
    .any       (any),
    .all       (all),
    .cnt       (cnt),
    .y_q       (y_q),
    .out_valid (out_valid),
    .acc       (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, then sample 1 time unit after the next rising edge.
  task automatic cycle(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tv,
                       input logic tc);
    @(negedge clk);
    a        = ta;
    b        = tb;
    in_valid = tv;
    acc_clr  = tc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    nchk     = 0;
    nfail    = 0;
    rst      = 1'b1;
    a        = '0;
    b        = '0;
    in_valid = 1'b0;
    acc_clr  = 1'b0;

    vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 5'd0};
    vecs[1] = '{16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 5'd1};
    vecs[2] = '{16'h0001, 16'h0000, 16'h0001, 1'b1, 1'b0, 5'd1};
    vecs[3] = '{16'h0001, 16'h0001, 16'h0001, 1'b1, 1'b0, 5'd1};
    vecs[4] = '{16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b1, 1'b1, 5'd16};
    vecs[5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 5'd16};
    vecs[6] = '{16'h8000, 16'h0001, 16'h8001, 1'b1, 1'b0, 5'd2};
    vecs[7] = '{16'h0F0F, 16'h00F0, 16'h0FFF, 1'b1, 1'b0, 5'd12};
    vecs[8] = '{16'h1234, 16'h4321, 16'h5335, 1'b1, 1'b0, 5'd8};
    vecs[9] = '{16'h7FFF, 16'h0000, 16'h7FFF, 1'b1, 1'b0, 5'd15};

    #1;
    chk("reset y_q", 32'(y_q), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset acc", 32'(acc), 32'h0);

    // Combinational path, exercised while reset is held to show it is unaffected.
    for (int i = 0; i < 10; i++) begin
      a = vecs[i].a;
      b = vecs[i].b;
      #1;
      chk($sformatf("vec%0d y", i), 32'(y), 32'(vecs[i].exp_y));
      chk($sformatf("vec%0d any", i), 32'(any), 32'(vecs[i].exp_any));
      chk($sformatf("vec%0d all", i), 32'(all), 32'(vecs[i].exp_all));
      chk($sformatf("vec%0d cnt", i), 32'(cnt), 32'(vecs[i].exp_cnt));
      #9;
    end

    @(negedge clk);
    rst = 1'b0;

    // Single capture gives exactly one cycle of out_valid.
    cycle(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    chk("cap y_q", 32'(y_q), 32'hFFFF);
    chk("cap out_valid", 32'(out_valid), 32'h1);
    chk("cap acc", 32'(acc), 32'hFFFF);
    cycle(16'h1111, 16'h0000, 1'b0, 1'b0);
    chk("hold y_q", 32'(y_q), 32'hFFFF);
    chk("hold out_valid", 32'(out_valid), 32'h0);
    cycle(16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("clr acc", 32'(acc), 32'h0);
    chk("clr y_q kept", 32'(y_q), 32'hFFFF);

    // Back-to-back accumulation.
    cycle(16'h0001, 16'h0000, 1'b1, 1'b0);
    chk("acc1", 32'(acc), 32'h0001);
    cycle(16'h0100, 16'h0000, 1'b1, 1'b0);
    chk("acc2", 32'(acc), 32'h0101);
    chk("b2b out_valid", 32'(out_valid), 32'h1);
    cycle(16'h8000, 16'h0000, 1'b1, 1'b0);
    chk("acc3", 32'(acc), 32'h8101);
    chk("b2b y_q", 32'(y_q), 32'h8000);
    chk("b2b out_valid 2", 32'(out_valid), 32'h1);
    cycle(16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("clr acc 2", 32'(acc), 32'h0);
    chk("clr out_valid", 32'(out_valid), 32'h0);

    // Clear and accumulate in the same cycle.
    cycle(16'hFF00, 16'h0000, 1'b1, 1'b0);
    chk("pre acc", 32'(acc), 32'hFF00);
    cycle(16'h00F0, 16'h000F, 1'b1, 1'b1);
    chk("clr+acc acc", 32'(acc), 32'h00FF);
    chk("clr+acc y_q", 32'(y_q), 32'h00FF);

    // Saturation at all-ones.
    cycle(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    cycle(16'h0001, 16'h0000, 1'b1, 1'b0);
    chk("sat acc", 32'(acc), 32'hFFFF);
    chk("sat y_q", 32'(y_q), 32'h0001);

    // Asynchronous reset between edges while out_valid=1 and acc!=0.
    cycle(16'h0042, 16'h0000, 1'b1, 1'b0);
    chk("pre-rst out_valid", 32'(out_valid), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst out_valid", 32'(out_valid), 32'h0);
    chk("arst y_q", 32'(y_q), 32'h0);
    chk("arst acc", 32'(acc), 32'h0);
    a = 16'h0C00;
    b = 16'h0003;
    #1;
    chk("arst y tracks", 32'(y), 32'h0C03);
    chk("arst cnt tracks", 32'(cnt), 32'd4);

    // in_valid already high when reset releases is taken at the first edge.
    a        = 16'h0030;
    b        = 16'h0000;
    in_valid = 1'b1;
    @(negedge clk);
    chk("in-rst out_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-rst y_q", 32'(y_q), 32'h0030);
    chk("post-rst acc", 32'(acc), 32'h0030);
    chk("post-rst out_valid", 32'(out_valid), 32'h1);
    cycle(16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("post-rst drop", 32'(out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
